player_motion_ctrl: RTL and testbench

- Parametrised successor to the fixed two-player position controller.
- Takes up to N_KEYS simultaneous USB HID keycodes from the SoC keycode PIO and the VGA vertical sync as frame reference.
- Updates X/Y for N_PLAYERS fighters once per frame: walking, edge-triggered jumps with gravity, screen-bound clamping.
- Outputs feed color_mapper directly.

---
 rtl/player_motion_ctrl_pkg.sv | 16 +
 rtl/player_motion_ctrl_if.sv | 23 ++
 rtl/player_axis.sv | 113 +++++++++++
 rtl/player_motion_ctrl.sv | 128 ++++++++++++
 tb/tb_player_motion_ctrl.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/player_motion_ctrl_pkg.sv
// Shared types and default key assignments for the fighter motion controller.
package fighter_pkg;

  typedef enum logic {GROUND, AIR} mstate_t;

  // USB HID usage codes: player 0 uses A/D/W, player 1 uses J/L/I.
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;
  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_J = 8'h0D;
  localparam logic [7:0] KEY_L = 8'h0F;
  localparam logic [7:0] KEY_I = 8'h0C;

  typedef logic [9:0] coord_t;

endpackage

// File: rtl/player_motion_ctrl_if.sv
// Keycode/frame inputs and per-player position outputs between the SoC side and the controller.
interface player_motion_ctrl_if #(
  parameter int N_PLAYERS = 2,
  parameter int N_KEYS    = 4,
  parameter int COORD_W   = 10
);
  logic                           frame_clk;
  logic [8*N_KEYS-1:0]            keycodes;
  logic [COORD_W*N_PLAYERS-1:0]   PlayerX;
  logic [COORD_W*N_PLAYERS-1:0]   PlayerY;
  logic [N_PLAYERS-1:0]           airborne;
  logic                           frame_tick;

  modport master (
    output frame_clk, keycodes,
    input  PlayerX, PlayerY, airborne, frame_tick
  );

  modport slave (
    input  frame_clk, keycodes,
    output PlayerX, PlayerY, airborne, frame_tick
  );
endinterface

// File: rtl/player_axis.sv
// One fighter: GROUND/AIR jump FSM, signed vertical velocity, X/Y registers with screen clamping.
module player_axis
  import fighter_pkg::*;
#(
  parameter int                 COORD_W   = 10,
  parameter int                 X_MIN     = 0,
  parameter int                 X_MAX     = 600,
  parameter int                 GROUND_Y  = 400,
  parameter int                 WALK_STEP = 2,
  parameter int                 JUMP_V0   = 12,
  parameter int                 GRAVITY   = 1,
  parameter logic [COORD_W-1:0] START_X   = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_i,
  input  logic               left_i,
  input  logic               right_i,
  input  logic               jump_i,
  input  logic               block_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic [COORD_W-1:0] x_prop_o,
  output logic               airborne_o
);

  localparam int VW = COORD_W - 1;
  localparam int YW = COORD_W + 2;

  localparam logic signed [COORD_W:0] STEP_S = (COORD_W+1)'(WALK_STEP);
  localparam logic signed [COORD_W:0] XMIN_S = (COORD_W+1)'(X_MIN);
  localparam logic signed [COORD_W:0] XMAX_S = (COORD_W+1)'(X_MAX);
  localparam logic signed [YW-1:0]    GY_S   = YW'(GROUND_Y);
  localparam logic signed [VW-1:0]    V0_S   = VW'(JUMP_V0);
  localparam logic signed [VW-1:0]    GRAV_S = VW'(GRAVITY);

  mstate_t               state_q, state_d;
  logic [COORD_W-1:0]    x_q, x_d;
  logic [COORD_W-1:0]    y_q, y_d;
  logic signed [VW-1:0]  vy_q, vy_d;
  logic                  jprev_q, jprev_d;

  logic signed [COORD_W:0] x_ext, x_walk;
  logic signed [YW-1:0]    y_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= GROUND;
      x_q     <= START_X;
      y_q     <= COORD_W'(GROUND_Y);
      vy_q    <= '0;
      jprev_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vy_q    <= vy_d;
      jprev_q <= jprev_d;
    end
  end

  // One extra bit keeps the step from wrapping past 0 or 2^COORD_W before clamping.
  always_comb begin
    x_ext  = signed'({1'b0, x_q});
    x_walk = x_ext;
    if (left_i && !right_i) begin
      x_walk = x_ext - STEP_S;
      if (x_walk < XMIN_S) x_walk = XMIN_S;
    end else if (right_i && !left_i) begin
      x_walk = x_ext + STEP_S;
      if (x_walk > XMAX_S) x_walk = XMAX_S;
    end
  end

  assign x_prop_o = x_walk[COORD_W-1:0];
  assign y_next   = signed'({2'b00, y_q}) - YW'(vy_q);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    vy_d    = vy_q;
    jprev_d = jprev_q;
    if (tick_i) begin
      jprev_d = jump_i;
      if (!block_i) x_d = x_prop_o;
      if (state_q == GROUND) begin
        if (jump_i && !jprev_q) begin
          state_d = AIR;
          vy_d    = V0_S;
        end
      end else begin
        if (y_next >= GY_S) begin
          state_d = GROUND;
          y_d     = COORD_W'(GROUND_Y);
          vy_d    = '0;
        end else if (y_next < 0) begin
          // Ceiling: pin to the top row and start falling from rest.
          y_d  = '0;
          vy_d = '0;
        end else begin
          y_d  = y_next[COORD_W-1:0];
          vy_d = vy_q - GRAV_S;
        end
      end
    end
  end

  assign x_o        = x_q;
  assign y_o        = y_q;
  assign airborne_o = (state_q == AIR);

endmodule

// File: rtl/player_motion_ctrl.sv
// Frame-synchronised multi-player position controller: frame_clk sync, key decode, optional pushbox.
// Optional feature: define PLAYER_PUSHBOX_EN to cancel walks that bring fighters closer than MIN_SEP.
module player_motion_ctrl
  import fighter_pkg::*;
#(
  parameter int                           N_PLAYERS = 2,
  parameter int                           N_KEYS    = 4,
  parameter int                           COORD_W   = 10,
  parameter int                           X_MIN     = 0,
  parameter int                           X_MAX     = 600,
  parameter int                           GROUND_Y  = 400,
  parameter int                           WALK_STEP = 2,
  parameter int                           JUMP_V0   = 12,
  parameter int                           GRAVITY   = 1,
  parameter int                           MIN_SEP   = 48,
  parameter logic [24*N_PLAYERS-1:0]      KEYMAP    = {KEY_A, KEY_D, KEY_W, KEY_J, KEY_L, KEY_I},
  parameter logic [COORD_W*N_PLAYERS-1:0] START_X   = {10'd100, 10'd500}
) (
  input  logic                Clk,
  input  logic                Reset,
  player_motion_ctrl_if.slave bus
);

  logic [1:0]             fsync_q;
  logic                   fprev_q;
  logic                   tick;
  logic [N_PLAYERS-1:0]   key_l, key_r, key_j, block;
  logic [COORD_W-1:0]     x  [N_PLAYERS];
  logic [COORD_W-1:0]     y  [N_PLAYERS];
  logic [COORD_W-1:0]     xp [N_PLAYERS];
  logic [N_PLAYERS-1:0]   airb;
  logic [COORD_W*N_PLAYERS-1:0] px, py;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      fsync_q <= '0;
      fprev_q <= 1'b0;
    end else begin
      fsync_q <= {fsync_q[0], bus.frame_clk};
      fprev_q <= fsync_q[1];
    end
  end

  assign tick           = fsync_q[1] & ~fprev_q;
  assign bus.frame_tick = tick;

  always_comb begin
    key_l = '0;
    key_r = '0;
    key_j = '0;
    for (int p = 0; p < N_PLAYERS; p++) begin
      for (int k = 0; k < N_KEYS; k++) begin
        if (bus.keycodes[8*k +: 8] != 8'h00) begin
          if (bus.keycodes[8*k +: 8] == KEYMAP[24*(N_PLAYERS-1-p)+16 +: 8]) key_l[p] = 1'b1;
          if (bus.keycodes[8*k +: 8] == KEYMAP[24*(N_PLAYERS-1-p)+8  +: 8]) key_r[p] = 1'b1;
          if (bus.keycodes[8*k +: 8] == KEYMAP[24*(N_PLAYERS-1-p)    +: 8]) key_j[p] = 1'b1;
        end
      end
    end
  end

`ifdef PLAYER_PUSHBOX_EN
  function automatic logic [COORD_W-1:0] absdiff(input logic [COORD_W-1:0] a,
                                                 input logic [COORD_W-1:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Both rules look only at this frame's old and proposed X, so no player order matters.
  always_comb begin
    block = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      for (int j = 0; j < N_PLAYERS; j++) begin
        if (i != j) begin
          if ((absdiff(xp[i], x[j])  < COORD_W'(MIN_SEP)) ||
              (absdiff(xp[i], xp[j]) < COORD_W'(MIN_SEP)))
            block[i] = 1'b1;
        end
      end
    end
  end
`else
  logic unused_pushbox;
  always_comb begin
    block          = '0;
    unused_pushbox = (MIN_SEP < 0);
    for (int p = 0; p < N_PLAYERS; p++) unused_pushbox = unused_pushbox ^ (^xp[p]);
  end
`endif

  for (genvar p = 0; p < N_PLAYERS; p++) begin : g_player
    player_axis #(
      .COORD_W   (COORD_W),
      .X_MIN     (X_MIN),
      .X_MAX     (X_MAX),
      .GROUND_Y  (GROUND_Y),
      .WALK_STEP (WALK_STEP),
      .JUMP_V0   (JUMP_V0),
      .GRAVITY   (GRAVITY),
      .START_X   (START_X[COORD_W*(N_PLAYERS-1-p) +: COORD_W])
    ) u_axis (
      .clk        (Clk),
      .rst        (Reset),
      .tick_i     (tick),
      .left_i     (key_l[p]),
      .right_i    (key_r[p]),
      .jump_i     (key_j[p]),
      .block_i    (block[p]),
      .x_o        (x[p]),
      .y_o        (y[p]),
      .x_prop_o   (xp[p]),
      .airborne_o (airb[p])
    );
  end

  always_comb begin
    px = '0;
    py = '0;
    for (int p = 0; p < N_PLAYERS; p++) begin
      px[COORD_W*p +: COORD_W] = x[p];
      py[COORD_W*p +: COORD_W] = y[p];
    end
  end

  assign bus.PlayerX  = px;
  assign bus.PlayerY  = py;
  assign bus.airborne = airb;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed bench for player_motion_ctrl with default parameters; honours PLAYER_PUSHBOX_EN.
module tb_player_motion_ctrl;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  player_motion_ctrl_if #(.N_PLAYERS(2), .N_KEYS(4), .COORD_W(10)) bus ();

  player_motion_ctrl dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic frames(input int n);
    for (int f = 0; f < n; f++) begin
      @(negedge clk);
      bus.frame_clk = 1'b1;
      repeat (4) @(negedge clk);
      bus.frame_clk = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  function automatic logic [31:0] p0x(); return {22'd0, bus.PlayerX[9:0]};   endfunction
  function automatic logic [31:0] p1x(); return {22'd0, bus.PlayerX[19:10]}; endfunction
  function automatic logic [31:0] p0y(); return {22'd0, bus.PlayerY[9:0]};   endfunction
  function automatic logic [31:0] p1y(); return {22'd0, bus.PlayerY[19:10]}; endfunction

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    bus.frame_clk = 1'b0;
    bus.keycodes  = '0;
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_p0x", p0x(), 100);
    check("rst_p0y", p0y(), 400);
    check("rst_p1x", p1x(), 500);
    check("rst_p1y", p1y(), 400);
    check("rst_airb", {30'd0, bus.airborne}, 0);
    check("rst_tick", {31'd0, bus.frame_tick}, 0);
    rst = 1'b0;

    // Idle frames leave everything in place.
    frames(3);
    check("idle_p0x", p0x(), 100);
    check("idle_p1x", p1x(), 500);
    check("idle_p0y", p0y(), 400);

    // Walk right with latency/tick-width observation on the first frame.
    bus.keycodes = {8'h00, 8'h00, 8'h00, 8'h07};
    @(negedge clk);
    bus.frame_clk = 1'b1;
    @(negedge clk);
    check("lat_tick_e1", {31'd0, bus.frame_tick}, 0);
    @(negedge clk);
    check("lat_tick_e2", {31'd0, bus.frame_tick}, 1);
    check("lat_x_e2", p0x(), 100);
    @(negedge clk);
    check("lat_tick_e3", {31'd0, bus.frame_tick}, 0);
    check("lat_x_e3", p0x(), 102);
    @(negedge clk);
    check("lat_tick_e4", {31'd0, bus.frame_tick}, 0);
    bus.frame_clk = 1'b0;
    repeat (4) @(negedge clk);
    frames(4);
    check("walk_p0x", p0x(), 110);
    check("walk_p1x", p1x(), 500);

    bus.keycodes = {8'h00, 8'h00, 8'h04, 8'h07};
    frames(2);
    check("both_p0x", p0x(), 110);

    // Jump held continuously.
    bus.keycodes = {8'h00, 8'h1A, 8'h00, 8'h00};
    frames(1);
    check("launch_y", p0y(), 400);
    check("launch_airb", {30'd0, bus.airborne}, 1);
    frames(1);
    check("air1_y", p0y(), 388);
    frames(1);
    check("air2_y", p0y(), 377);
    frames(1);
    check("air3_y", p0y(), 367);
    frames(21);
    check("air24_y", p0y(), 388);
    check("air24_airb", {30'd0, bus.airborne}, 1);
    frames(1);
    check("land_y", p0y(), 400);
    check("land_airb", {30'd0, bus.airborne}, 0);
    check("land_p1y", p1y(), 400);
    frames(2);
    check("hold_no_rejump", {30'd0, bus.airborne}, 0);
    bus.keycodes = '0;
    frames(1);
    bus.keycodes = {8'h1A, 8'h00, 8'h00, 8'h00};
    frames(1);
    check("rejump_airb", {30'd0, bus.airborne}, 1);
    frames(5);
    check("mid_y", p0y(), 350);

    // Reset in the middle of a jump and of a tick pulse.
    @(negedge clk);
    bus.frame_clk = 1'b1;
    repeat (2) @(negedge clk);
    check("pre_rst_tick", {31'd0, bus.frame_tick}, 1);
    rst = 1'b1;
    #1;
    check("midrst_p0x", p0x(), 100);
    check("midrst_p0y", p0y(), 400);
    check("midrst_airb", {30'd0, bus.airborne}, 0);
    check("midrst_tick", {31'd0, bus.frame_tick}, 0);
    bus.frame_clk = 1'b0;
    bus.keycodes  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Walk the two players toward each other.
    bus.keycodes = {8'h00, 8'h00, 8'h0D, 8'h07};
    frames(25);
    check("approach_p0x", p0x(), 150);
    check("approach_p1x", p1x(), 450);
    bus.keycodes = {8'h00, 8'h00, 8'h00, 8'h07};
    frames(125);
    check("setup_p0x", p0x(), 400);
    bus.keycodes = {8'h00, 8'h00, 8'h0D, 8'h07};
    frames(1);
`ifdef PLAYER_PUSHBOX_EN
    check("push_p0x", p0x(), 400);
    check("push_p1x", p1x(), 450);
    bus.keycodes = {8'h00, 8'h00, 8'h00, 8'h0F};
    frames(74);
`else
    check("push_p0x", p0x(), 402);
    check("push_p1x", p1x(), 448);
    bus.keycodes = {8'h00, 8'h00, 8'h00, 8'h0F};
    frames(75);
`endif

    // Right boundary.
    check("redge_598", p1x(), 598);
    frames(1);
    check("redge_600", p1x(), 600);
    frames(1);
    check("redge_hold", p1x(), 600);

    // Left boundary, with the key duplicated in every slot.
    bus.keycodes = {8'h04, 8'h04, 8'h04, 8'h04};
`ifdef PLAYER_PUSHBOX_EN
    frames(199);
`else
    frames(200);
`endif
    check("ledge_2", p0x(), 2);
    frames(1);
    check("ledge_0", p0x(), 0);
    frames(1);
    check("ledge_hold", p0x(), 0);
    check("ledge_p1x", p1x(), 600);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
